// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the byte-enable stage and data memory.
// Queues word-granular store entries, drains them in order over a req/gnt
// handshake, and stalls the pipeline when full or when a load hits a pending
// entry. Optional feature macro: SBUF_MERGE_EN (merge a store into the
// youngest entry when it targets the same word).
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [3:0]                 st_byteen,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       stall,
    output logic                       m_req,
    output logic [31:0]                m_addr,
    output logic [31:0]                m_wdata,
    output logic [3:0]                 m_byteen,
    input  logic                       m_gnt,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry storage. Kept in flops and cleared on reset so the head view
    // reads as zero straight out of reset.
    logic [29:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  be_mem   [DEPTH];

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;

    logic st_live;
    logic full;
    logic merge;
    logic push;
    logic pop;
    logic hit;
    logic [DEPTH-1:0] hit_vec;

    assign st_live = st_valid & (st_byteen != 4'b0000);
    assign full    = (count_reg == FULL_CNT);

`ifdef SBUF_MERGE_EN
    logic [PW-1:0] tail_last;
    logic [31:0]   merge_data;

    assign tail_last = tail_reg - PW'(1);

    // Merge into the youngest entry unless that entry is the head leaving
    // on this very edge.
    assign merge = st_live & (count_reg != '0) &
                   (addr_mem[tail_last] == st_addr[31:2]) &
                   ~((count_reg == CW'(1)) & m_gnt);

    // Byte-wise overlay of the incoming store onto the youngest entry.
    always_comb begin
        merge_data = data_mem[tail_last];
        for (int b = 0; b < 4; b++) begin
            if (st_byteen[b]) begin
                merge_data[8*b +: 8] = st_data[8*b +: 8];
            end
        end
    end
`else
    assign merge = 1'b0;
`endif

    // A full buffer refuses the store even when the head pops this cycle.
    assign push = st_live & ~full & ~merge;
    assign pop  = m_req & m_gnt;

    // Per-entry load hit against occupied slots only, using pre-edge contents.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            logic          occupied;
            assign offset      = PW'(gi) - head_reg;
            assign occupied    = ({1'b0, offset} < count_reg);
            assign hit_vec[gi] = occupied & (addr_mem[gi] == ld_addr[31:2]);
        end
    endgenerate

    assign hit   = |hit_vec;
    assign stall = (st_live & full & ~merge) | (ld_valid & hit);

    // Per-entry storage update: allocate at the tail, or overlay on merge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    addr_mem[gi] <= '0;
                    data_mem[gi] <= '0;
                    be_mem[gi]   <= '0;
                end else if (push && (tail_reg == PW'(gi))) begin
                    addr_mem[gi] <= st_addr[31:2];
                    data_mem[gi] <= st_data;
                    be_mem[gi]   <= st_byteen;
                end
`ifdef SBUF_MERGE_EN
                else if (merge && (tail_last == PW'(gi))) begin
                    data_mem[gi] <= merge_data;
                    be_mem[gi]   <= be_mem[gi] | st_byteen;
                end
`endif
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign m_req    = (count_reg != '0);
    assign m_addr   = {addr_mem[head_reg], 2'b00};
    assign m_wdata  = data_mem[head_reg];
    assign m_byteen = be_mem[head_reg];
    assign count    = count_reg;

    // Byte-offset bits are never used; collected here to keep lint quiet.
    logic unused_bits;
    assign unused_bits = &{1'b0, st_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, hand-written
// merge/drain/reset sequences, and randomized traffic against a queue model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_byteen;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        stall;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        m_gnt;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byteen(st_byteen),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .stall(stall), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_byteen(m_byteen), .m_gnt(m_gnt), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    ent_t q[$];

    // Outputs sampled during the most recent step (pre-edge).
    logic [2:0]  s_count;
    logic        s_stall;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance it.
    task automatic step(input logic rst, input logic sv, input logic [31:0] sa,
                        input logic [31:0] sd, input logic [3:0] sbe,
                        input logic lv, input logic [31:0] la, input logic g);
        int   n;
        logic live, mrg, hit, ex_stall, do_pop, do_push;
        ent_t e;
        @(negedge clk);
        reset = rst; st_valid = sv; st_addr = sa; st_data = sd; st_byteen = sbe;
        ld_valid = lv; ld_addr = la; m_gnt = g;
        #1;
        s_count = count; s_stall = stall; s_req = m_req;
        s_addr = m_addr; s_data = m_wdata; s_be = m_byteen;

        n    = q.size();
        live = sv && (sbe != 4'b0);
        mrg  = 1'b0;
`ifdef SBUF_MERGE_EN
        if (live && n > 0 && q[n-1].a == sa[31:2] && !(n == 1 && g)) mrg = 1'b1;
`endif
        hit = 1'b0;
        foreach (q[i]) if (q[i].a == la[31:2]) hit = 1'b1;
        ex_stall = (live && n == DEPTH && !mrg) || (lv && hit);

        chk("model_count", 32'(s_count), 32'(n));
        chk("model_stall", 32'(s_stall), 32'(ex_stall));
        chk("model_req",   32'(s_req),   32'(n > 0));
        if (n > 0) begin
            chk("model_addr", s_addr, {q[0].a, 2'b00});
            chk("model_data", s_data, q[0].d);
            chk("model_be",   32'(s_be), 32'(q[0].b));
        end
        $display("cyc rst=%0b st=%0b a=%08h be=%h ld=%0b la=%08h g=%0b | cnt=%0d stall=%0b req=%0b ma=%08h",
                 rst, sv, sa, sbe, lv, la, g, s_count, s_stall, s_req, s_addr);

        do_pop  = g && n > 0;
        do_push = live && n < DEPTH && !mrg;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (mrg) begin
                e = q[n-1];
                for (int b = 0; b < 4; b++)
                    if (sbe[b]) e.d[8*b +: 8] = sd[8*b +: 8];
                e.b = e.b | sbe;
                q[n-1] = e;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.a = sa[31:2]; e.d = sd; e.b = sbe;
                q.push_back(e);
            end
        end
    endtask

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [3:0]  sbe;
        logic        lv;
        logic [31:0] la;
        logic        g;
        logic [2:0]  e_cnt;
        logic        e_stall;
        logic        e_req;
        logic        chk_m;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
    } vec_t;

    vec_t vt[23];

    function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic [3:0] sbe,
                                logic lv, logic [31:0] la, logic g,
                                logic [2:0] ec, logic es, logic er, logic cm,
                                logic [31:0] ea, logic [31:0] ed, logic [3:0] eb);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.sbe = sbe; v.lv = lv; v.la = la; v.g = g;
        v.e_cnt = ec; v.e_stall = es; v.e_req = er; v.chk_m = cm;
        v.e_addr = ea; v.e_data = ed; v.e_be = eb;
        return v;
    endfunction

    initial begin
        reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_byteen = 0;
        ld_valid = 0; ld_addr = 0; m_gnt = 0;

        // Directed table: inputs for the cycle and required pre-edge outputs.
        vt[0]  = mk(1, 32'h1003, 32'h1100_0000, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h1000, 32'h1100_0000, 4'b1000);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 32'h1000, 32'h1100_0000, 4'b1000);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[4]  = mk(1, 32'h00, 32'hD0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[5]  = mk(1, 32'h04, 32'hD4, 4'hF, 0, 0, 0, 1, 0, 1, 1, 32'h00, 32'hD0, 4'hF);
        vt[6]  = mk(1, 32'h08, 32'hD8, 4'hF, 0, 0, 0, 2, 0, 1, 1, 32'h00, 32'hD0, 4'hF);
        vt[7]  = mk(1, 32'h0C, 32'hDC, 4'hF, 0, 0, 0, 3, 0, 1, 1, 32'h00, 32'hD0, 4'hF);
        vt[8]  = mk(1, 32'h10, 32'hD10, 4'hF, 0, 0, 0, 4, 1, 1, 1, 32'h00, 32'hD0, 4'hF);
        vt[9]  = mk(1, 32'h10, 32'hD10, 4'hF, 0, 0, 1, 4, 1, 1, 1, 32'h00, 32'hD0, 4'hF);
        vt[10] = mk(1, 32'h10, 32'hD10, 4'hF, 0, 0, 0, 3, 0, 1, 1, 32'h04, 32'hD4, 4'hF);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 1, 32'h04, 32'hD4, 4'hF);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 1, 32'h08, 32'hD8, 4'hF);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 32'h0C, 32'hDC, 4'hF);
        vt[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 32'h10, 32'hD10, 4'hF);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[16] = mk(1, 32'h20, 32'h2020, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[17] = mk(0, 0, 0, 0, 1, 32'h22, 0, 1, 1, 1, 1, 32'h20, 32'h2020, 4'hF);
        vt[18] = mk(0, 0, 0, 0, 1, 32'h24, 0, 1, 0, 1, 1, 32'h20, 32'h2020, 4'hF);
        vt[19] = mk(0, 0, 0, 0, 1, 32'h22, 1, 1, 1, 1, 1, 32'h20, 32'h2020, 4'hF);
        vt[20] = mk(0, 0, 0, 0, 1, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[21] = mk(1, 32'h50, 32'h55, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_count", 32'(s_count), 0);
        chk("reset_req",   32'(s_req), 0);
        chk("reset_addr",  s_addr, 0);
        chk("reset_data",  s_data, 0);
        chk("reset_be",    32'(s_be), 0);
        chk("reset_stall", 32'(s_stall), 0);

        for (int i = 0; i < 23; i++) begin
            step(0, vt[i].sv, vt[i].sa, vt[i].sd, vt[i].sbe, vt[i].lv, vt[i].la, vt[i].g);
            chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_stall", i), 32'(s_stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d_req", i),   32'(s_req),   32'(vt[i].e_req));
            if (vt[i].chk_m) begin
                chk($sformatf("vec%0d_addr", i), s_addr, vt[i].e_addr);
                chk($sformatf("vec%0d_data", i), s_data, vt[i].e_data);
                chk($sformatf("vec%0d_be", i),   32'(s_be), 32'(vt[i].e_be));
            end
        end

        // Two byte stores into the same word.
        step(0, 1, 32'h40, 32'h0000_00AA, 4'b0001, 0, 0, 0);
        step(0, 1, 32'h41, 32'h0000_BB00, 4'b0010, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef SBUF_MERGE_EN
        chk("merge_count", 32'(s_count), 1);
        chk("merge_be",    32'(s_be), 32'(4'b0011));
        chk("merge_data",  32'(s_data[15:0]), 32'h0000_BBAA);
`else
        chk("nomerge_count", 32'(s_count), 2);
        chk("nomerge_be",    32'(s_be), 32'(4'b0001));
        chk("nomerge_data",  32'(s_data[7:0]), 32'h0000_00AA);
`endif

        // Streaming stores with grant held high from empty.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 32'h100 + 32'(4*i), 32'hC000 + 32'(i), 4'hF, 0, 0, 1);
            checks++;
            if (s_count > 1) begin
                failures++;
                $display("FAIL stream_count actual=%0d required<=1", s_count);
            end
            chk("stream_stall", 32'(s_stall), 0);
            if (i > 0) chk("stream_order", s_addr, 32'h100 + 32'(4*(i-1)));
        end

        // Reset mid-drain discards pending entries.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h200, 32'h1, 4'hF, 0, 0, 0);
        step(0, 1, 32'h204, 32'h2, 4'hF, 0, 0, 0);
        step(0, 1, 32'h208, 32'h3, 4'hF, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("pre_reset_count", 32'(s_count), 3);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_count", 32'(s_count), 0);
        chk("post_reset_req",   32'(s_req), 0);

        // Randomized traffic over a small address set to provoke hits and merges.
        for (int i = 0; i < 400; i++) begin
            logic        r_rst, r_sv, r_lv, r_g;
            logic [31:0] r_sa, r_la, r_sd;
            logic [3:0]  r_be;
            r_rst = ($urandom_range(0, 99) < 2);
            r_sv  = ($urandom_range(0, 99) < 60);
            r_sa  = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
            r_sd  = $urandom;
            r_be  = 4'($urandom);
            r_lv  = ($urandom_range(0, 99) < 40);
            r_la  = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
            r_g   = ($urandom_range(0, 99) < 35);
            step(r_rst, r_sv, r_sa, r_sd, r_be, r_lv, r_la, r_g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

- Posted-write buffer between the byte-enable stage and data memory, in the MEM stage.
- Accepts aligned store lanes (word address, lane-positioned data, 4-bit byte write mask) and queues them in a small FIFO.
- Drains entries to the memory write port through a request/grant handshake.
- Stalls the pipeline when full, or when a load word-address hits any pending entry.

## Interface
- DEPTH, 4: number of FIFO entries; power of two, minimum 2.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- st_valid  input  1  store request from MEM stage.
- st_addr  input  32  store byte address; only [31:2] is used.
- st_data  input  32  lane-positioned store data.
- st_byteen  input  4  byte write mask; bit i enables st_data[8i+7:8i].
- ld_valid  input  1  load in MEM stage.
- ld_addr  input  32  load byte address; only [31:2] is compared.
- stall  output  1  freeze pipeline (combinational).
- m_req  output  1  head entry valid toward memory.
- m_addr  output  32  {head word address, 2'b00}.
- m_wdata  output  32  head entry data.
- m_byteen  output  4  head entry byte mask.
- m_gnt  input  1  memory accepts head on this edge when m_req=1.
- count  output  $clog2(DEPTH)+1  occupied entries (debug/verification).

## Operation
- Storage: DEPTH entries of {word_addr[29:0], data[31:0], byteen[3:0]}, plus head pointer, tail pointer and count.
- Pointers wrap modulo DEPTH.
- Enqueue: occurs when st_valid=1, st_byteen!=0 and (count<DEPTH or merge).
  - Writes tail, advances tail, count+1.
  - A store with st_byteen=0 is ignored and never stalls.
- Drain: m_req=(count>0); m_addr/m_wdata/m_byteen always show the head entry.
  - m_req=1 and m_gnt=1 at an edge pops head, count-1.
  - m_gnt is ignored when count=0.
- Simultaneous enqueue and pop:
  - count unchanged; both pointers advance.
  - Not permitted at count=DEPTH; a full buffer stalls the store even if the pop happens that cycle.
- Stall: stall = (st_valid & st_byteen!=0 & count==DEPTH & ~merge) | (ld_valid & hit).
  - hit = any occupied entry whose word_addr == ld_addr[31:2].
  - The comparison uses pre-edge contents only.
  - A load stalls until every matching entry has drained; memory is then authoritative.
- Stores are word-granular entries; the block never reorders them. Memory sees writes in program order.

## Timing
- Reset values:
  - count=0, head=tail=0.
  - m_req=0, m_byteen=0, m_wdata=0, m_addr=0.
  - stall=0 unless driven by inputs (an empty buffer can never produce hit).
- Enqueue latency: an entry accepted at edge N is visible on m_* from edge N at the earliest.
  - If the buffer was empty: m_req=1 during cycle N→N+1, the earliest pop is edge N+1.
- Throughput: one enqueue and one pop per cycle.
- Reset asserted mid-drain discards all entries. Lost posted writes on reset are accepted behaviour.
- stall has no registered component; it deasserts in the same cycle the blocking condition clears.

## Configuration
- SBUF_MERGE_EN defined:
  - merge = st_valid & st_byteen!=0 & count>0 & (tail-1 entry word_addr == st_addr[31:2]) & ~(count==1 & m_gnt).
  - On merge, for each set bit of st_byteen, that byte of the tail-1 entry's data is overwritten, and byteen |= st_byteen.
  - No pointer or count change.
  - A merge is allowed when full and never stalls.
- SBUF_MERGE_EN undefined: merge is constant 0; every accepted store occupies its own entry.

## Test plan
- Reset then sb 0x11 @0x1003, mem gnt held 0 → count=1, m_addr=0x1000, m_byteen=4'b1000, m_wdata=0x11000000, m_req=1; raise gnt → count=0 next edge.
- DEPTH=4, gnt=0, four sw to 0x0,0x4,0x8,0xC; fifth sw to 0x10 → stall=1, count stays 4. Pulse gnt one cycle → pops 0x0, fifth enters on the following edge, order 0x4,0x8,0xC,0x10.
- Pending sw @0x20, lw @0x22 with gnt=0 → stall=1. lw @0x24 → stall=0. Grant → stall drops the same cycle count reaches 0.
- sb 0xAA @0x40 then sb 0xBB @0x41, gnt=0:
  - With SBUF_MERGE_EN → count=1, m_byteen=4'b0011, m_wdata[15:0]=0xBBAA.
  - Without → count=2.
- Continuous stores with gnt=1 every cycle from empty → count never exceeds 1, stall never asserts, memory sees writes in issue order. Reset asserted with count=3 → count=0, m_req=0 next edge.
